// File: rtl/des_byte_serializer_if.sv
// Block-in / byte-out bus of the DES output serializer.
// Handshake: a block transfers at a rising clk2x edge where blk_valid & blk_ready & clk_en.
interface des_byte_serializer_if #(
  parameter int BYTES = 8
);
  localparam int NBW = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [8*BYTES-1:0] blk_in;
  logic               blk_valid;
  logic               blk_last;
  logic [NBW-1:0]     blk_nbytes;
  logic               blk_ready;
  logic               down_full;
  logic [7:0]         byte_out;
  logic               byte_en;
  logic               stream_done;
  logic [31:0]        byte_cnt;

  modport master (
    output blk_in, blk_valid, blk_last, blk_nbytes, down_full,
    input  blk_ready, byte_out, byte_en, stream_done, byte_cnt
  );

  modport slave (
    input  blk_in, blk_valid, blk_last, blk_nbytes, down_full,
    output blk_ready, byte_out, byte_en, stream_done, byte_cnt
  );
endinterface

// File: rtl/des_byte_serializer.sv
// Splits DES output blocks into an MSB-first byte stream with a one-block holding
// register so consecutive blocks stream without a bubble; the last block is truncated.
module des_byte_serializer #(
  parameter int BYTES = 8
) (
  input  logic                 clk2x,
  input  logic                 srst,
  input  logic                 clk_en,
  des_byte_serializer_if.slave bus,
  output logic [1:0]           o_dbg_state
);
  localparam int W  = 8*BYTES;
  localparam int RW = $clog2(BYTES+1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_sr, r_hold;
  logic [RW-1:0]  r_rem, r_hold_rem;
  logic           r_sr_last, r_hold_last, r_hold_full;
  logic           r_rst_q;
  logic [7:0]     r_byte;
  logic           r_byte_en;
  logic [31:0]    r_cnt;

  logic           w_emit, w_finish, w_final, w_accept;
  logic [RW-1:0]  w_blk_rem;

  // r_rst_q keeps blk_ready low through reset and raises it one edge after release.
  assign bus.blk_ready   = ~r_hold_full & (r_state != ST_DONE) & r_rst_q;
  assign w_emit          = clk_en & ~bus.down_full & (r_rem != '0);
  assign w_finish        = w_emit & (r_rem == RW'(1));
  assign w_final         = w_finish & r_sr_last;
  assign w_accept        = clk_en & bus.blk_valid & bus.blk_ready;
  assign w_blk_rem       = bus.blk_last ? (RW'(bus.blk_nbytes) + RW'(1)) : RW'(BYTES);

  assign bus.byte_out    = r_byte;
  assign bus.byte_en     = r_byte_en;
  assign bus.stream_done = (r_state == ST_DONE);
  assign bus.byte_cnt    = r_cnt;
  assign o_dbg_state     = r_state;

  always_comb begin
    w_state_nxt = r_state;
    if (clk_en) begin
      case (r_state)
        ST_IDLE:  if (w_accept) w_state_nxt = ST_SHIFT;
        ST_SHIFT: begin
          if (w_final)
            w_state_nxt = ST_DONE;
          else if (w_finish && !r_hold_full && !w_accept)
            w_state_nxt = ST_IDLE;
        end
        ST_DONE:  w_state_nxt = ST_DONE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk2x) begin
    if (!srst) begin
      r_state     <= ST_IDLE;
      r_sr        <= '0;
      r_hold      <= '0;
      r_rem       <= '0;
      r_hold_rem  <= '0;
      r_sr_last   <= 1'b0;
      r_hold_last <= 1'b0;
      r_hold_full <= 1'b0;
      r_rst_q     <= 1'b0;
      r_byte      <= '0;
      r_byte_en   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_rst_q   <= 1'b1;
      r_state   <= w_state_nxt;
      r_byte_en <= w_emit;
      if (w_emit) begin
        r_byte <= r_sr[W-1 -: 8];
        r_cnt  <= r_cnt + 32'd1;
      end
      if (clk_en) begin
        if (w_final) begin
          // Anything parked in HOLD past the end of stream is dropped.
          r_rem       <= '0;
          r_sr_last   <= 1'b0;
          r_hold_full <= 1'b0;
        end else if ((r_rem == '0) || w_finish) begin
          if (r_hold_full) begin
            r_sr        <= r_hold;
            r_rem       <= r_hold_rem;
            r_sr_last   <= r_hold_last;
            r_hold_full <= w_accept;
            if (w_accept) begin
              r_hold      <= bus.blk_in;
              r_hold_rem  <= w_blk_rem;
              r_hold_last <= bus.blk_last;
            end
          end else if (w_accept) begin
            r_sr      <= bus.blk_in;
            r_rem     <= w_blk_rem;
            r_sr_last <= bus.blk_last;
          end else if (w_finish) begin
            r_rem     <= '0;
            r_sr_last <= 1'b0;
          end
        end else begin
          if (w_emit) begin
            r_sr  <= {r_sr[W-9:0], 8'h00};
            r_rem <= r_rem - RW'(1);
          end
          if (w_accept) begin
            r_hold      <= bus.blk_in;
            r_hold_rem  <= w_blk_rem;
            r_hold_last <= bus.blk_last;
            r_hold_full <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_des_byte_serializer.sv
// Bench for des_byte_serializer: directed scenarios plus randomized traffic, all checked
// against a byte-queue reference model of the serializer.
module tb_des_byte_serializer;
  logic       clk2x  = 1'b0;
  logic       srst   = 1'b0;
  logic       clk_en = 1'b1;
  logic [1:0] dbg_state;

  des_byte_serializer_if #(.BYTES(8)) bus();

  des_byte_serializer #(.BYTES(8)) dut (
    .clk2x       (clk2x),
    .srst        (srst),
    .clk_en      (clk_en),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk2x = ~clk2x;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // reference model: expected bytes in emission order, bit 8 marks the stream's final byte
  logic [8:0]  exp_q[$];
  logic        m_en = 1'b0;
  logic [7:0]  m_byte = 8'h00;
  logic [31:0] m_cnt = 32'd0;
  logic        m_done = 1'b0;
  logic        m_rst = 1'b0;
  logic        m_rel = 1'b0;
  logic        mon_on = 1'b0;
  logic        rdy_s = 1'b0;
  int          acc_cnt = 0;

  int   mode = 0;
  logic ce_man = 1'b1;
  logic df_man = 1'b0;
  int   cyc = 0;
  int   run = 0;
  int   max_run = 0;
  logic rdy_low_seen = 1'b0;

  initial forever begin
    logic [8:0] e;
    int n;
    @(posedge clk2x);
    if (!srst) begin
      exp_q.delete();
      m_en = 1'b0; m_byte = 8'h00; m_cnt = 32'd0; m_done = 1'b0;
      m_rst = 1'b1; m_rel = 1'b0; mon_on = 1'b1;
    end else begin
      m_rel = m_rst;
      m_rst = 1'b0;
      m_en  = clk_en && !bus.down_full && (exp_q.size() > 0);
      if (m_en) begin
        e = exp_q.pop_front();
        m_byte = e[7:0];
        m_cnt  = m_cnt + 32'd1;
        if (e[8]) m_done = 1'b1;
      end
      if (clk_en && bus.blk_valid && rdy_s) begin
        n = bus.blk_last ? int'(bus.blk_nbytes) + 1 : 8;
        for (int i = 0; i < n; i++) begin
          e = {bus.blk_last && (i == n-1), bus.blk_in[63-8*i -: 8]};
          exp_q.push_back(e);
        end
        acc_cnt++;
      end
    end
  end

  // output checks, away from the active edge
  initial forever begin
    @(negedge clk2x);
    rdy_s = bus.blk_ready;
    if (mon_on) begin
      check("byte_en", {63'd0, bus.byte_en}, {63'd0, m_en});
      check("byte_out", {56'd0, bus.byte_out}, {56'd0, m_byte});
      check("byte_cnt", {32'd0, bus.byte_cnt}, {32'd0, m_cnt});
      check("stream_done", {63'd0, bus.stream_done}, {63'd0, m_done});
      if (m_rst || m_done) check("blk_ready_low", {63'd0, bus.blk_ready}, 64'd0);
      else if (m_rel)      check("blk_ready_rel", {63'd0, bus.blk_ready}, 64'd1);
      if (bus.byte_en) run++; else run = 0;
      if (run > max_run) max_run = run;
      if (!bus.blk_ready && !m_rst) rdy_low_seen = 1'b1;
    end
  end

  // enable / backpressure knobs: 0 manual, 1 full every third edge, 2 random
  initial forever begin
    @(negedge clk2x);
    cyc++;
    case (mode)
      0: begin clk_en = ce_man; bus.down_full = df_man; end
      1: begin clk_en = 1'b1; bus.down_full = (cyc % 3 == 0); end
      default: begin
        clk_en        = ($urandom_range(0, 7) != 0);
        bus.down_full = ($urandom_range(0, 3) == 0);
      end
    endcase
  end

  // driver tasks
  task automatic send_block(input logic [63:0] d, input logic last, input logic [2:0] nb);
    int a0;
    int t;
    a0 = acc_cnt;
    t  = 0;
    bus.blk_in = d; bus.blk_last = last; bus.blk_nbytes = nb; bus.blk_valid = 1'b1;
    do begin
      @(negedge clk2x);
      t++;
    end while (acc_cnt == a0 && t < 200);
    if (acc_cnt == a0) check("accept_timeout", 64'(acc_cnt), 64'(a0 + 1));
  endtask

  task automatic drain();
    int t;
    t = 0;
    bus.blk_valid = 1'b0;
    while ((exp_q.size() != 0 || bus.byte_en) && t < 400) begin
      @(negedge clk2x);
      t++;
    end
    if (t >= 400) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk2x);
  endtask

  task automatic do_reset();
    srst = 1'b0;
    @(negedge clk2x);
    srst = 1'b1;
    @(negedge clk2x);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int t;
    bus.blk_in = 64'hDEAD_BEEF_0BAD_F00D; bus.blk_valid = 1'b1;
    bus.blk_last = 1'b0; bus.blk_nbytes = 3'd0;
    srst = 1'b0;

    // reset with a block offered
    repeat (3) @(negedge clk2x);
    check("rst_no_accept", 64'(acc_cnt), 64'd0);
    check("rst_ready", {63'd0, bus.blk_ready}, 64'd0);
    check("rst_cnt", {32'd0, bus.byte_cnt}, 64'd0);
    bus.blk_valid = 1'b0;
    srst = 1'b1;
    @(negedge clk2x);
    check("ready_after_rst", {63'd0, bus.blk_ready}, 64'd1);

    // single block
    send_block(64'h0123_4567_89AB_CDEF, 1'b0, 3'd5);
    drain();
    check("single_cnt", {32'd0, bus.byte_cnt}, 64'd8);
    check("single_last_byte", {56'd0, bus.byte_out}, 64'hEF);

    // back-to-back
    do_reset();
    max_run = 0; rdy_low_seen = 1'b0;
    for (int i = 0; i < 4; i++) send_block(rnd64(), 1'b0, 3'($urandom_range(0, 7)));
    drain();
    check("b2b_run", 64'(max_run), 64'd32);
    check("b2b_ready_low", {63'd0, rdy_low_seen}, 64'd1);
    check("b2b_cnt", {32'd0, bus.byte_cnt}, 64'd32);

    // backpressure every third edge
    do_reset();
    mode = 1;
    for (int i = 0; i < 2; i++) send_block(rnd64(), 1'b0, 3'd0);
    drain();
    mode = 0;
    check("bp_cnt", {32'd0, bus.byte_cnt}, 64'd16);

    // truncated last block
    do_reset();
    send_block(64'h1122_3344_5566_7788, 1'b0, 3'd1);
    send_block(64'hAABB_CCDD_EEFF_0011, 1'b1, 3'd2);
    drain();
    check("last_done", {63'd0, bus.stream_done}, 64'd1);
    check("last_ready", {63'd0, bus.blk_ready}, 64'd0);
    check("last_cnt", {32'd0, bus.byte_cnt}, 64'd11);
    check("last_byte", {56'd0, bus.byte_out}, 64'hCC);

    // clk_en pause mid-block
    do_reset();
    send_block(rnd64(), 1'b0, 3'd3);
    bus.blk_valid = 1'b0;
    repeat (3) @(negedge clk2x);
    ce_man = 1'b0;
    repeat (2) @(negedge clk2x);
    ce_man = 1'b1;
    drain();
    check("ce_cnt", {32'd0, bus.byte_cnt}, 64'd8);

    // reset after the third byte
    do_reset();
    send_block(rnd64(), 1'b0, 3'd0);
    bus.blk_valid = 1'b0;
    t = 0;
    while (m_cnt != 32'd3 && t < 50) begin
      @(negedge clk2x);
      t++;
    end
    check("midrst_reach3", {32'd0, bus.byte_cnt}, 64'd3);
    srst = 1'b0;
    @(negedge clk2x);
    srst = 1'b1;
    check("midrst_cnt0", {32'd0, bus.byte_cnt}, 64'd0);
    repeat (4) @(negedge clk2x);
    check("midrst_quiet", {32'd0, bus.byte_cnt}, 64'd0);
    send_block(64'hF0E1_D2C3_B4A5_9687, 1'b0, 3'd0);
    drain();
    check("midrst_fresh_cnt", {32'd0, bus.byte_cnt}, 64'd8);
    check("midrst_fresh_last", {56'd0, bus.byte_out}, 64'h87);

    // randomized traffic ending in a truncated block
    do_reset();
    mode = 2;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.blk_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk2x);
      end
      send_block(rnd64(), (i == 19), 3'($urandom_range(0, 7)));
    end
    drain();
    mode = 0;
    check("rand_done", {63'd0, bus.stream_done}, 64'd1);
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/des_byte_serializer.md
# des_byte_serializer

Output-side byte serializer for the bhargava MPEG/DES datapath. It accepts 64-bit blocks from the DES engine over a valid/ready handshake and emits them as a byte stream, most-significant byte first, one byte per enabled cycle. It honours downstream programmable-full backpressure and truncates the final block of a stream to its true byte count. It is the inverse of the input-side byte-to-block assembler.

## Interface
Parameters:
- BYTES, 8: bytes per block. Block width is 8*BYTES bits.

Ports:
- clk2x  in  1  clock; all state updates on its rising edge.
- srst  in  1  reset, synchronous, active-low.
- clk_en  in  1  global enable; 0 freezes all state (see Operation).
- blk_in  in  64  DES output block; blk_in[63:56] is emitted first.
- blk_valid  in  1  blk_in, blk_last and blk_nbytes are valid.
- blk_last  in  1  this block is the last block of the stream.
- blk_nbytes  in  3  valid bytes minus 1 (0..7 means 1..8); used only when blk_last=1, otherwise treated as 7.
- blk_ready  out  1  block accepted at an edge where blk_valid & blk_ready & clk_en.
- down_full  in  1  downstream prog-full; no byte is emitted at an edge where it is 1.
- byte_out  out  8  output byte.
- byte_en  out  1  byte_out valid this cycle.
- stream_done  out  1  sticky; last byte of the last block has been emitted.
- byte_cnt  out  32  total bytes emitted since reset.

## Operation
- Storage: a holding register (HOLD) and a shift register (SR) with a remaining-byte count `rem` (0..8). SR is active when rem>0.
- blk_ready = ~hold_full & ~done & srst. The registered reset term keeps blk_ready at 0 during reset.
- Accept: if SR is empty or finishing this edge (rem==1 and a byte is emitted), the block loads SR directly. Otherwise it loads HOLD. While SR finishes, HOLD moves into SR at the same edge, so consecutive blocks produce no bubble.
- Emit: at an edge with clk_en=1, down_full=0 and rem>0, the block does the following: byte_out <= SR[63:56], byte_en <= 1, SR shifts left by 8, rem decrements, byte_cnt increments.
- If the emit condition is false, byte_en <= 0 and byte_out holds its previous value.
- Truncation: a block with blk_last=1 loads rem = blk_nbytes+1. Its trailing bytes are never emitted.
- States:
  - IDLE: SR empty.
  - SHIFT: rem>0.
  - DONE: the last byte of a blk_last block has been emitted.
- Transitions:
  - IDLE→SHIFT on accept.
  - SHIFT→IDLE when the final byte is emitted and HOLD is empty.
  - SHIFT→DONE when the final byte of a last block is emitted.
- DONE: stream_done=1, blk_ready=0. The block stays in DONE until srst=0. A block already in HOLD when DONE is reached is an upstream protocol error; it is discarded.
- clk_en=0: all registers hold, except byte_en, which is cleared to 0 so no byte is duplicated. No accept or emit occurs.
- byte_cnt wraps modulo 2^32.

## Timing
- Reset values (at the edge with srst=0):
  - byte_out=0, byte_en=0, blk_ready=0, stream_done=0, byte_cnt=0.
  - SR, HOLD and rem are cleared; state is IDLE.
- Reset mid-block discards all buffered bytes. blk_ready returns to 1 on the first edge with srst=1.
- Latency: a block accepted at edge k with SR empty presents byte 0 with byte_en=1 in the cycle following edge k+1, assuming down_full=0 at edge k+1. Bytes 1..7 follow on consecutive edges.
- Throughput is 1 byte/cycle. blk_ready deasserts after HOLD fills, and reasserts the cycle after HOLD moves into SR.
- down_full is sampled at the edge itself. A 1 at edge j means byte_en=0 after edge j, with no byte lost or reordered.
- stream_done rises at the same edge that registers the final byte (byte_en=1 and stream_done=1 in the same cycle).
- Simultaneous accept and HOLD→SR move in the same edge is legal; the new block goes to HOLD.

## Test plan
- Reset: hold srst=0 for 3 edges while blk_valid=1 and down_full=0 -> all outputs 0, no accept; blk_ready=1 one edge after release.
- Single block: blk_in=0x0123456789ABCDEF, blk_last=0, accepted at edge k -> bytes 01,23,45,67,89,AB,CD,EF on edges k+1..k+8, byte_cnt=8, then IDLE.
- Back-to-back: 4 blocks with blk_valid held high -> 32 contiguous byte_en cycles with no gap; blk_ready low while HOLD is full; byte order matches block order.
- Backpressure: down_full=1 on every third edge during 2 blocks -> 16 bytes in correct order; byte_en=0 exactly at the stalled edges; byte_cnt=16.
- Last block: block 0x1122334455667788 (last=0) followed by 0xAABBCCDDEEFF0011 with blk_last=1, blk_nbytes=2 -> 11..88 then AA,BB,CC; stream_done=1 with CC; blk_ready=0 afterwards; byte_cnt=11.
- Disruption: clk_en=0 for 2 cycles mid-block -> byte_en=0, no duplicate or skipped byte. srst=0 after the 3rd byte of a block -> no further bytes; byte_cnt=0; a fresh block then serializes normally.
